nx_msg_assembler: RTL and testbench
===================================

// Module: nx_msg_assembler
// PURPOSE
//  Host-side ingress stage feeding the mesh inbound stream (mesh node row 0, column 0, north port).
//  - Accepts narrow host beats and assembles them LSB-first into full-width mesh messages.
//  - Holds assembled messages in a 2-entry FIFO and presents them on a valid/ready stream.
//  - Reports a saturating count of delivered messages and a sticky short-transfer error.
// PARAMETERS
//  HOST_W  8   width of one host beat, in bits
//  MSG_W   32  message width; tied to NXConstants::MESSAGE_WIDTH at instantiation
//  BEATS   derived localparam = ceil(MSG_W / HOST_W); must be >= 2
// PORTS
//  i_clk          in   1       clock; all logic is on its rising edge
//  i_rst          in   1       reset; synchronous, active-low
//  i_host_data    in   HOST_W  host beat payload
//  i_host_last    in   1       final beat of a host transfer
//  i_host_valid   in   1       host beat valid
//  o_host_ready   out  1       host beat accepted when valid & ready
//  o_msg_data     out  MSG_W   assembled message, FIFO head
//  o_msg_valid    out  1       message valid; drives mesh i_inbound_valid
//  i_msg_ready    in   1       mesh o_inbound_ready
//  i_clear        in   1       clears o_msg_count and o_err_short
//  o_msg_count    out  16      messages delivered; saturates at 16'hFFFF
//  o_err_short    out  1       sticky: a transfer ended mid-message
// BEHAVIOUR
//  Reset (i_rst==0 at a clock edge):
//  - beat counter 0, assembly register 0, FIFO emptied.
//  - o_msg_valid 0, o_msg_count 0, o_err_short 0.
//  - o_host_ready is forced 0 combinationally while i_rst is low.
//  - A reset mid-message discards the partial message and all FIFO contents.
//  Host handshake:
//  - o_host_ready = (fifo_count != 2), decoded from registered state only.
//  - No combinational path from i_msg_ready to o_host_ready.
//  - A beat is accepted when i_host_valid & o_host_ready.
//  Assembly:
//  - The accepted beat at index b writes asm[b*HOST_W +: HOST_W]; bits at or above MSG_W are dropped.
//  - The beat counter increments per accepted beat and wraps BEATS-1 -> 0.
//  - On the beat at index BEATS-1, the completed message (including the current beat) is pushed into the FIFO that cycle.
//  - i_host_last on beat BEATS-1 has no extra effect.
//  - i_host_last on beat b < BEATS-1: nothing is pushed, the partial message is discarded, the counter returns to 0, and o_err_short is set next cycle.
//  - Lower slices are not cleared between messages; each message fully overwrites them.
//  Latency:
//  - Final beat accepted at cycle N -> o_msg_valid=1 at N+1 if the FIFO was empty.
//  - Sustained throughput is 1 message per BEATS cycles with i_msg_ready=1.
//  FIFO (2 entries, registered head):
//  - o_msg_valid = (fifo_count != 0); o_msg_data = head entry.
//  - Data and valid are held stable while valid & !ready.
//  - Pop on o_msg_valid & i_msg_ready.
//  - Simultaneous push and pop at count 1: count stays 1 and the head advances to the new message.
//  - Push is impossible at count 2 because ready is low.
//  Status:
//  - o_msg_count increments on each pop; it holds at 16'hFFFF once reached.
//  - i_clear: o_msg_count <= 0 and o_err_short <= 0.
//  - i_clear wins over a same-cycle pop or short error, so both read 0 next cycle.
//  - i_clear does not affect the datapath or the FIFO.
// TESTING
//  1. Beats 0x11,0x22,0x33,0x44 back-to-back, ready=1 -> o_msg_data=32'h44332211, valid 1 cycle after beat 4; count=1.
//  2. Hold i_msg_ready=0 and send 3 messages -> after 2 messages o_host_ready=0, 3rd message's first beat stalls; raise ready -> all 3 delivered in order with data unchanged.
//  3. Beats 0xAA,0xBB with i_host_last on 0xBB, then 4 beats 0x01..0x04 -> o_err_short=1; only 32'h04030201 emitted; count=1.
//  4. Pulse i_clear in the same cycle as a pop with count=5 -> count=0 and err=0 next cycle; the message is still delivered.
//  5. Drive i_rst=0 after 2 of 4 beats and with 1 message queued -> o_msg_valid=0, o_host_ready=0 during reset; after reset a full 4-beat message emerges uncorrupted.
//  6. Preload count to 16'hFFFE via 65534 messages (or force), deliver 3 more -> count saturates at 16'hFFFF.

Source files
------------

// File: rtl/nx_msg_assembler.sv
// nx_msg_assembler: packs narrow host beats LSB-first into full-width mesh
// messages, buffers them in a 2-entry FIFO with a registered head, and keeps
// a saturating delivered-message count plus a sticky short-transfer flag.
`timescale 1ns/1ps
module nx_msg_assembler #(
    parameter int HOST_W = 8,
    parameter int MSG_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [HOST_W-1:0] i_host_data,
    input  logic              i_host_last,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    output logic [MSG_W-1:0]  o_msg_data,
    output logic              o_msg_valid,
    input  logic              i_msg_ready,
    input  logic              i_clear,
    output logic [15:0]       o_msg_count,
    output logic              o_err_short
);
    localparam int BEATS = (MSG_W + HOST_W - 1) / HOST_W;
    localparam int ASM_W = BEATS * HOST_W;
    localparam int BW    = $clog2(BEATS);

    logic [BW-1:0]    beat_cnt_reg, beat_cnt_next;
    logic [ASM_W-1:0] asm_reg, asm_next;
    logic [MSG_W-1:0] mem_reg [2];
    logic             wr_ptr_reg, rd_ptr_reg;
    logic [1:0]       fifo_count_reg, fifo_count_next;
    logic [15:0]      msg_count_reg;
    logic             err_short_reg;

    logic accept, last_beat, push, pop, short_end;

    // Ready depends only on registered FIFO occupancy (and reset), never on i_msg_ready.
    assign o_host_ready = i_rst && (fifo_count_reg != 2'd2);
    assign accept       = i_host_valid && o_host_ready;
    assign last_beat    = (beat_cnt_reg == BW'(BEATS - 1));
    assign push         = accept && last_beat;
    assign short_end    = accept && i_host_last && !last_beat;
    assign o_msg_valid  = (fifo_count_reg != 2'd0);
    assign pop          = o_msg_valid && i_msg_ready;
    assign o_msg_data   = mem_reg[rd_ptr_reg];
    assign o_msg_count  = msg_count_reg;
    assign o_err_short  = err_short_reg;

    // Each slice takes the current beat when it is the one being filled, so the
    // final beat lands in the pushed message in the same cycle.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
            assign asm_next[gi*HOST_W +: HOST_W] =
                (accept && beat_cnt_reg == BW'(gi)) ? i_host_data
                                                     : asm_reg[gi*HOST_W +: HOST_W];
        end
    endgenerate

    // Beat index advances per accepted beat; wraps after a full message or a short end.
    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        if (accept) begin
            if (last_beat || i_host_last) begin
                beat_cnt_next = '0;
            end else begin
                beat_cnt_next = beat_cnt_reg + 1'b1;
            end
        end
    end

    // FIFO occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        fifo_count_next = fifo_count_reg;
        case ({push, pop})
            2'b10:   fifo_count_next = fifo_count_reg + 2'd1;
            2'b01:   fifo_count_next = fifo_count_reg - 2'd1;
            default: fifo_count_next = fifo_count_reg;
        endcase
    end

    // Assembly and FIFO pointer state; reset drops any partial message and queued data.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            beat_cnt_reg   <= '0;
            asm_reg        <= '0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            fifo_count_reg <= 2'd0;
        end else begin
            beat_cnt_reg   <= beat_cnt_next;
            asm_reg        <= asm_next;
            fifo_count_reg <= fifo_count_next;
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // FIFO storage, one register per entry; bits of the assembly above MSG_W are dropped.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge i_clk) begin
                if (!i_rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && wr_ptr_reg == 1'(gi)) begin
                    mem_reg[gi] <= asm_next[MSG_W-1:0];
                end
            end
        end
    endgenerate

    // Status: clear has priority over a same-cycle pop or short-transfer error.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            msg_count_reg <= 16'd0;
            err_short_reg <= 1'b0;
        end else if (i_clear) begin
            msg_count_reg <= 16'd0;
            err_short_reg <= 1'b0;
        end else begin
            if (pop && msg_count_reg != 16'hFFFF) msg_count_reg <= msg_count_reg + 16'd1;
            if (short_end) err_short_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nx_msg_assembler.sv
// Directed bench for nx_msg_assembler: stimulus pushes expected messages into
// a queue, an independent monitor pops and compares on every delivered message.
`timescale 1ns/1ps
module tb_nx_msg_assembler;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  host_data;
    logic        host_last;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic        clear;
    logic [15:0] msg_count;
    logic        err_short;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    nx_msg_assembler #(.HOST_W(8), .MSG_W(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_host_data (host_data),
        .i_host_last (host_last),
        .i_host_valid(host_valid),
        .o_host_ready(host_ready),
        .o_msg_data  (msg_data),
        .o_msg_valid (msg_valid),
        .i_msg_ready (msg_ready),
        .i_clear     (clear),
        .o_msg_count (msg_count),
        .o_err_short (err_short)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every handshake on the message stream is one transaction.
    always @(negedge clk) begin
        if (msg_valid && msg_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_msg: got %h expected none", msg_data);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("msg out %h (expected %h)", msg_data, mon_exp);
                check("msg_data", msg_data, mon_exp);
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic last);
        int  n;
        logic acc;
        n = 0;
        host_valid = 1'b1;
        host_data  = d;
        host_last  = last;
        do begin
            @(negedge clk);
            acc = host_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            $display("FAIL beat_timeout: got no accept expected accept of %h", d);
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [31:0] m);
        for (int i = 0; i < 4; i++) send_beat(m[i*8 +: 8], i == 3);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b0; host_data = 8'h00; host_last = 1'b0; host_valid = 1'b0;
        msg_ready = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, msg_valid}, 32'd0);
        check("reset_count", {16'd0, msg_count}, 32'd0);
        check("reset_err", {31'd0, err_short}, 32'd0);
        check("reset_ready", {31'd0, host_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("ready_after_reset", {31'd0, host_ready}, 32'd1);

        // 1: single message, latency one cycle after final beat
        msg_ready = 1'b1;
        exp_q.push_back(32'h44332211);
        send_msg(32'h44332211);
        check("latency_valid", {31'd0, msg_valid}, 32'd1);
        drain();
        check("count_t1", {16'd0, msg_count}, 32'd1);

        // 2: backpressure, FIFO fills, third message stalls, order kept
        msg_ready = 1'b0;
        exp_q.push_back(32'hA4A3A2A1);
        exp_q.push_back(32'hB4B3B2B1);
        exp_q.push_back(32'hC4C3C2C1);
        send_msg(32'hA4A3A2A1);
        send_msg(32'hB4B3B2B1);
        check("full_ready_low", {31'd0, host_ready}, 32'd0);
        fork
            send_msg(32'hC4C3C2C1);
            begin
                repeat (3) begin @(posedge clk); #1; end
                check("stall_ready_low", {31'd0, host_ready}, 32'd0);
                check("held_valid", {31'd0, msg_valid}, 32'd1);
                check("held_data", msg_data, 32'hA4A3A2A1);
                msg_ready = 1'b1;
            end
        join
        drain();
        check("count_t2", {16'd0, msg_count}, 32'd4);

        // 3: short transfer discarded and flagged
        clear_pulse();
        check("clear_count", {16'd0, msg_count}, 32'd0);
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        check("err_set", {31'd0, err_short}, 32'd1);
        check("short_no_push", {31'd0, msg_valid}, 32'd0);
        exp_q.push_back(32'h04030201);
        send_msg(32'h04030201);
        drain();
        check("count_t3", {16'd0, msg_count}, 32'd1);

        // 4: clear wins over a same-cycle pop
        clear_pulse();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(32'h10203040 + i);
            send_msg(32'h10203040 + i);
        end
        drain();
        check("count_five", {16'd0, msg_count}, 32'd5);
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        check("err_set_t4", {31'd0, err_short}, 32'd1);
        msg_ready = 1'b0;
        exp_q.push_back(32'hDEADBEEF);
        send_msg(32'hDEADBEEF);
        msg_ready = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_pop_count", {16'd0, msg_count}, 32'd0);
        check("clear_pop_err", {31'd0, err_short}, 32'd0);
        check("clear_pop_delivered", exp_q.size(), 32'd0);

        // 5: reset mid-message with one message queued
        msg_ready = 1'b0;
        exp_q.push_back(32'h0BADF00D);
        send_msg(32'h0BADF00D);
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("rst_ready_comb", {31'd0, host_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_valid", {31'd0, msg_valid}, 32'd0);
        check("rst_ready", {31'd0, host_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        msg_ready = 1'b1;
        exp_q.push_back(32'h5A6B7C8D);
        send_msg(32'h5A6B7C8D);
        drain();
        check("count_t5", {16'd0, msg_count}, 32'd1);

        // 6: saturation at 16'hFFFF
        force dut.msg_count_reg = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.msg_count_reg;
        exp_q.push_back(32'h11111111);
        send_msg(32'h11111111);
        drain();
        check("count_ffff", {16'd0, msg_count}, 32'h0000FFFF);
        exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h33333333);
        send_msg(32'h22222222);
        send_msg(32'h33333333);
        drain();
        check("count_sat", {16'd0, msg_count}, 32'h0000FFFF);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
